// File: rtl/sram_dp_buf_if.sv
// Port bundle for sram_dp_buf: write port, read port and clear engine.
// The master side is the datapath/readout; the slave side is the buffer.
interface sram_dp_buf_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
);
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wbe;
    logic              ren;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output wen, waddr, wdata, wbe,
        output ren, raddr, clr_req,
        input  rdata, rvalid,
        input  clr_busy, clr_done
    );

    modport slave (
        input  wen, waddr, wdata, wbe,
        input  ren, raddr, clr_req,
        output rdata, rvalid,
        output clr_busy, clr_done
    );
endinterface

// File: rtl/sram_dp_buf.sv
// Simple-dual-port output buffer with byte-enable writes, 1/2-cycle
// registered reads, optional write-to-read forwarding and a zero-fill engine.
module sram_dp_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8192,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 1,
    parameter bit BYPASS = 1
) (
    input logic          clk,
    input logic          rst,
    sram_dp_buf_if.slave bus
);
    localparam int NB = DATA_W / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              busy;

    logic              wr_acc;
    logic              rd_acc;
    logic              rd_oob;
    logic              hit;
    logic [ADDR_W-1:0] ridx;

    logic              s1_v;
    logic              s1_oob;
    logic              s1_hit;
    logic [NB-1:0]     s1_be;
    logic [DATA_W-1:0] s1_wd;
    logic [DATA_W-1:0] s1_raw;
    logic [DATA_W-1:0] s1_word;

    logic              fin_v;
    logic [DATA_W-1:0] fin_d;

    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    assign busy   = (state == S_CLEAR);
    assign wr_acc = bus.wen && !busy
                  && ({1'b0, bus.waddr} < DEPTH_X);
    assign rd_acc = bus.ren && !busy;
    assign rd_oob = ({1'b0, bus.raddr} >= DEPTH_X);
    assign ridx   = rd_oob ? '0 : bus.raddr;
    assign hit    = BYPASS && wr_acc && rd_acc
                  && (bus.waddr == bus.raddr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.clr_req) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                    end
                end
                S_CLEAR: begin
                    if (cnt == LAST) state <= S_DONE;
                    else             cnt   <= cnt + 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // A reset edge aborts the clear without writing the current word.
    always_ff @(posedge clk) begin
        if (busy && !rst) begin
            mem[cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wbe[i])
                    mem[bus.waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) s1_v <= 1'b0;
        else     s1_v <= rd_acc;
    end

    // Old contents are sampled here; forwarded bytes are merged one stage later.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            s1_raw <= mem[ridx];
            s1_oob <= rd_oob;
            s1_hit <= hit;
            s1_be  <= bus.wbe;
            s1_wd  <= bus.wdata;
        end
    end

    always_comb begin
        s1_word = s1_raw;
        for (int i = 0; i < NB; i++) begin
            if (s1_hit && s1_be[i])
                s1_word[8*i +: 8] = s1_wd[8*i +: 8];
        end
        if (s1_oob) s1_word = '0;
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              s2_v;
        logic [DATA_W-1:0] s2_d;

        always_ff @(posedge clk) begin
            if (rst) s2_v <= 1'b0;
            else     s2_v <= s1_v;
        end

        always_ff @(posedge clk) begin
            if (s1_v) s2_d <= s1_word;
        end

        assign fin_v = s2_v;
        assign fin_d = s2_d;
    end else begin : g_lat1
        assign fin_v = s1_v;
        assign fin_d = s1_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= fin_v;
            if (fin_v) rdata_q <= fin_d;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.clr_busy = busy;
    assign bus.clr_done = (state == S_DONE);
endmodule

// File: tb/tb_sram_dp_buf.sv
// Bench for sram_dp_buf: two configurations driven in lockstep and
// compared every cycle against an array/timeline model of the buffer.
module tb_sram_dp_buf;
    logic        clk = 1'b0;
    logic        rst;
    logic        wen, ren, clr_req;
    logic [3:0]  waddr, raddr, wbe;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    sram_dp_buf_if #(.DATA_W(32), .ADDR_W(4)) ia ();
    sram_dp_buf_if #(.DATA_W(32), .ADDR_W(4)) ib ();

    assign ia.wen = wen;     assign ib.wen = wen;
    assign ia.waddr = waddr; assign ib.waddr = waddr;
    assign ia.wdata = wdata; assign ib.wdata = wdata;
    assign ia.wbe = wbe;     assign ib.wbe = wbe;
    assign ia.ren = ren;     assign ib.ren = ren;
    assign ia.raddr = raddr; assign ib.raddr = raddr;
    assign ia.clr_req = clr_req;
    assign ib.clr_req = clr_req;

    sram_dp_buf #(
        .DATA_W(32), .DEPTH(16), .RD_LAT(1), .BYPASS(1)
    ) ua (
        .clk(clk), .rst(rst), .bus(ia)
    );

    sram_dp_buf #(
        .DATA_W(32), .DEPTH(12), .RD_LAT(2), .BYPASS(0)
    ) ub (
        .clk(clk), .rst(rst), .bus(ib)
    );

    logic [31:0] o_rd [2];
    logic        o_rv [2];
    logic        o_bs [2];
    logic        o_dn [2];

    assign o_rd[0] = ia.rdata;    assign o_rd[1] = ib.rdata;
    assign o_rv[0] = ia.rvalid;   assign o_rv[1] = ib.rvalid;
    assign o_bs[0] = ia.clr_busy; assign o_bs[1] = ib.clr_busy;
    assign o_dn[0] = ia.clr_done; assign o_dn[1] = ib.clr_done;

    int          depth [2] = '{16, 12};
    int          lat   [2] = '{1, 2};
    bit          byp   [2] = '{1'b1, 1'b0};
    logic [31:0] mm    [2][16];
    bit          kn    [2][16];
    bit          busy_m[2];
    bit          done_m[2];
    int          ptr   [2];
    bit          pv    [2][4];
    bit          pk    [2][4];
    logic [31:0] pd    [2][4];
    logic [31:0] last  [2];
    bit          lastk [2];
    int          cyc;
    int          errs;
    int          checks;

    function automatic logic [31:0] merge(
        input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit w, input logic [3:0] wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input bit r, input logic [3:0] ra,
                        input bit cr, input bit rs);
        wen = w; waddr = wa; wdata = wd; wbe = be;
        ren = r; raddr = ra; clr_req = cr; rst = rs;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            bit bp, dp;
            int s;
            bp = busy_m[d];
            dp = done_m[d];
            s  = (cyc + lat[d]) % 4;
            if (rs) begin
                if (bp) kn[d][ptr[d]] = 1'b0;
                busy_m[d] = 1'b0;
                done_m[d] = 1'b0;
                for (int k = 0; k < 4; k++) pv[d][k] = 1'b0;
                last[d]  = '0;
                lastk[d] = 1'b1;
            end else begin
                if (r && !bp) begin
                    pv[d][s] = 1'b1;
                    if (int'(ra) >= depth[d]) begin
                        pd[d][s] = '0;
                        pk[d][s] = 1'b1;
                    end else begin
                        pd[d][s] = (byp[d] && w && wa == ra)
                                 ? merge(mm[d][ra], wd, be) : mm[d][ra];
                        pk[d][s] = kn[d][ra];
                    end
                end
                if (w && !bp && int'(wa) < depth[d]) begin
                    mm[d][wa] = merge(mm[d][wa], wd, be);
                    if (be == 4'hF) kn[d][wa] = 1'b1;
                end
                if (bp) begin
                    mm[d][ptr[d]] = '0;
                    kn[d][ptr[d]] = 1'b1;
                    ptr[d]++;
                    if (ptr[d] == depth[d]) begin
                        busy_m[d] = 1'b0;
                        done_m[d] = 1'b1;
                    end
                end else if (dp) begin
                    done_m[d] = 1'b0;
                end else if (cr) begin
                    busy_m[d] = 1'b1;
                    ptr[d]    = 0;
                end
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            bit ev;
            int s;
            s  = cyc % 4;
            ev = pv[d][s];
            if (ev) begin
                pv[d][s] = 1'b0;
                last[d]  = pd[d][s];
                lastk[d] = pk[d][s];
            end
            chk($sformatf("rvalid[%0d] cyc%0d", d, cyc), 32'(o_rv[d]), 32'(ev));
            if (lastk[d])
                chk($sformatf("rdata[%0d] cyc%0d", d, cyc), o_rd[d], last[d]);
            chk($sformatf("clr_busy[%0d] cyc%0d", d, cyc),
                32'(o_bs[d]), 32'(busy_m[d]));
            chk($sformatf("clr_done[%0d] cyc%0d", d, cyc),
                32'(o_dn[d]), 32'(done_m[d]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 0, 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        step(1, a, d, be, 0, 4'd0, 0, 0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(0, 4'd0, 32'd0, 4'd0, 1, a, 0, 0);
    endtask

    task automatic fill_ones();
        for (int a = 0; a < 16; a++)
            wr(4'(a), 32'hFFFF_FFFF, 4'hF);
    endtask

    initial begin
        cyc = 0; errs = 0; checks = 0;
        for (int d = 0; d < 2; d++) begin
            busy_m[d] = 0; done_m[d] = 0; ptr[d] = 0;
            for (int a = 0; a < 16; a++) begin
                mm[d][a] = '0;
                kn[d][a] = 1'b0;
            end
        end

        step(0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 0, 1);
        step(0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 0, 1);
        idle(1);

        // Initial clear with dropped requests while busy, then a DONE-cycle read.
        step(0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 1, 0);
        wr(4'd5, 32'h1234_5678, 4'hF);
        rd(4'd5);
        idle(14);
        rd(4'd5);
        idle(3);

        wr(4'd5, 32'hDEAD_BEEF, 4'hF);
        rd(4'd5);
        idle(3);

        wr(4'd3, 32'h1122_3344, 4'hF);
        wr(4'd3, 32'hAABB_CCDD, 4'h5);
        rd(4'd3);
        idle(3);

        step(1, 4'd7, 32'hCAFE_F00D, 4'hF, 1, 4'd7, 0, 0);
        rd(4'd7);
        idle(3);

        wr(4'd2, 32'h0102_0304, 4'hF);
        step(1, 4'd2, 32'hA5A5_A5A5, 4'h6, 1, 4'd2, 0, 0);
        rd(4'd2);
        idle(3);

        rd(4'd9);
        wr(4'd9, 32'h9999_9999, 4'hF);
        rd(4'd9);
        wr(4'd0, 32'h0BAD_F00D, 4'h0);
        rd(4'd0);
        idle(3);

        wr(4'd13, 32'h5555_5555, 4'hF);
        rd(4'd13);
        rd(4'd12);
        rd(4'd11);
        idle(3);

        fill_ones();
        step(0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 1, 0);
        for (int i = 0; i < 18; i++)
            step(i == 3, 4'd4, 32'h7777_7777, 4'hF, i == 4, 4'd4,
                 i == 6, 0);
        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(3);

        fill_ones();
        step(0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 1, 0);
        idle(8);
        step(0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 0, 1);
        idle(3);
        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(3);

        for (int i = 0; i < 400; i++) begin
            bit rs;
            rs = ($urandom % 150) == 0;
            step(!rs && ($urandom % 2 == 1), 4'($urandom), $urandom,
                 4'($urandom), !rs && ($urandom % 2 == 1), 4'($urandom),
                 !rs && ($urandom % 40 == 0), rs);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
